// File: rtl/param_count_capture.sv
// Parametrised up/down modulo counter with one-shot stop, synchronous load,
// capture register with valid flag and a registered terminal-count pulse.
module param_count_capture #(
    parameter int unsigned       WIDTH    = 8,
    parameter bit                AUTO_CAP = 1'b1,
    parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count,
    input  logic             dir,
    input  logic             one_shot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    input  logic             capture,
    output logic [WIDTH-1:0] cnt,
    output logic             q,
    output logic [WIDTH-1:0] reg_out,
    output logic             reg_valid,
    output logic             done
);

    typedef enum logic {RUN, DONE} state_t;

    state_t           state;
    logic             clamp_pend;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] load_clamped;
    logic             run_en;
    logic             term;
    logic             cap_en;

    // The reset value is a constant; it is clamped against mod_val on the
    // first cycle after reset so the async reset path stays constant.
    always_comb begin
        cur          = (clamp_pend && (cnt > mod_val)) ? mod_val : cnt;
        load_clamped = (load_val > mod_val) ? mod_val : load_val;
        run_en       = count && (state == RUN);
        term         = run_en && !load && (dir ? (cur == '0) : (cur == mod_val));
        cap_en       = capture || (AUTO_CAP && term);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            done       <= 1'b0;
            cnt        <= RST_VAL;
            q          <= 1'b0;
            reg_out    <= '0;
            reg_valid  <= 1'b0;
            clamp_pend <= 1'b1;
        end else begin
            clamp_pend <= 1'b0;
            q          <= term;

            if (cap_en) begin
                reg_out   <= cur;
                reg_valid <= 1'b1;
            end

            if (load) begin
                cnt   <= load_clamped;
                state <= RUN;
                done  <= 1'b0;
            end else if (term && !one_shot) begin
                cnt <= dir ? mod_val : '0;
            end else if (term) begin
                cnt   <= cur;
                state <= DONE;
                done  <= 1'b1;
            end else if (run_en) begin
                // Natural 2^WIDTH overflow when mod_val was lowered below cnt.
                cnt <= dir ? (cur - WIDTH'(1)) : (cur + WIDTH'(1));
            end else begin
                cnt <= cur;
            end
        end
    end

endmodule

// File: tb/tb_param_count_capture.sv
// Directed self-checking bench for param_count_capture (WIDTH=4, AUTO_CAP=1).
module tb_param_count_capture;
    localparam int W = 4;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         count    = 1'b0;
    logic         dir      = 1'b0;
    logic         one_shot = 1'b0;
    logic         load     = 1'b0;
    logic         capture  = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] mod_val  = '0;
    logic [W-1:0] cnt;
    logic         q;
    logic [W-1:0] reg_out;
    logic         reg_valid;
    logic         done;

    int total = 0;
    int bad   = 0;

    int exp_cnt1[7] = '{1, 2, 3, 4, 5, 0, 1};
    int exp_q1[7]   = '{0, 0, 0, 0, 0, 1, 0};
    int exp_cnt2[4] = '{1, 0, 9, 8};
    int exp_q2[4]   = '{0, 0, 1, 0};

    param_count_capture #(
        .WIDTH(W),
        .AUTO_CAP(1'b1),
        .RST_VAL(4'd0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .count(count),
        .dir(dir),
        .one_shot(one_shot),
        .load(load),
        .load_val(load_val),
        .mod_val(mod_val),
        .capture(capture),
        .cnt(cnt),
        .q(q),
        .reg_out(reg_out),
        .reg_valid(reg_valid),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        mod_val = 4'd5;
        #2;
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_reg_out", 32'(reg_out), 0);
        chk("rst_reg_valid", 32'(reg_valid), 0);
        chk("rst_done", 32'(done), 0);
        #10;
        rst_n = 1'b1;

        // 1: up wrap with auto capture
        count = 1'b1;
        dir   = 1'b0;
        chk("t1_cnt0", 32'(cnt), 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("t1_cnt%0d", i + 1), 32'(cnt), 32'(exp_cnt1[i]));
            chk($sformatf("t1_q%0d", i + 1), 32'(q), 32'(exp_q1[i]));
            if (i == 5) begin
                chk("t1_reg_out", 32'(reg_out), 5);
                chk("t1_reg_valid", 32'(reg_valid), 1);
            end
        end

        // 2: down wrap after load
        count    = 1'b0;
        mod_val  = 4'd9;
        load_val = 4'd2;
        load     = 1'b1;
        tick();
        chk("t2_load", 32'(cnt), 2);
        load  = 1'b0;
        dir   = 1'b1;
        count = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t2_cnt%0d", i + 1), 32'(cnt), 32'(exp_cnt2[i]));
            chk($sformatf("t2_q%0d", i + 1), 32'(q), 32'(exp_q2[i]));
            if (i == 2) chk("t2_reg_out", 32'(reg_out), 0);
        end

        // 3: one-shot stop then clamped load
        count    = 1'b0;
        dir      = 1'b0;
        one_shot = 1'b1;
        mod_val  = 4'd3;
        load_val = 4'd0;
        load     = 1'b1;
        tick();
        chk("t3_load0", 32'(cnt), 0);
        load  = 1'b0;
        count = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("t3_cnt%0d", i), 32'(cnt), 32'(i));
            chk($sformatf("t3_done%0d", i), 32'(done), 0);
        end
        tick();
        chk("t3_frozen", 32'(cnt), 3);
        chk("t3_done", 32'(done), 1);
        chk("t3_q", 32'(q), 1);
        tick();
        chk("t3_still_frozen", 32'(cnt), 3);
        chk("t3_still_done", 32'(done), 1);
        chk("t3_q_drop", 32'(q), 0);
        load_val = 4'd12;
        load     = 1'b1;
        tick();
        chk("t3_clamp", 32'(cnt), 3);
        chk("t3_done_clr", 32'(done), 0);

        // 4: load/capture conflicts
        count    = 1'b0;
        one_shot = 1'b0;
        mod_val  = 4'd9;
        load_val = 4'd4;
        load     = 1'b1;
        tick();
        chk("t4_pre", 32'(cnt), 4);
        load_val = 4'd7;
        capture  = 1'b1;
        tick();
        chk("t4_cap_pre_load", 32'(reg_out), 4);
        chk("t4_cnt_loaded", 32'(cnt), 7);
        capture  = 1'b0;
        load_val = 4'd9;
        tick();
        chk("t4_at_term", 32'(cnt), 9);
        count    = 1'b1;
        load_val = 4'd2;
        tick();
        chk("t4_load_wins", 32'(cnt), 2);
        chk("t4_no_q", 32'(q), 0);
        chk("t4_no_autocap", 32'(reg_out), 4);

        // 5: mod_val=0 back-to-back terminal events
        count    = 1'b0;
        mod_val  = 4'd0;
        load_val = 4'd0;
        tick();
        chk("t5_load", 32'(cnt), 0);
        load  = 1'b0;
        count = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5_cnt%0d", i), 32'(cnt), 0);
            chk($sformatf("t5_q%0d", i), 32'(q), 1);
            chk($sformatf("t5_done%0d", i), 32'(done), 0);
        end
        count = 1'b0;
        tick();
        chk("t5_q_off", 32'(q), 0);

        // 6: async reset in DONE with a pending q
        one_shot = 1'b1;
        mod_val  = 4'd6;
        load_val = 4'd5;
        load     = 1'b1;
        tick();
        chk("t6_load", 32'(cnt), 5);
        load  = 1'b0;
        count = 1'b1;
        tick();
        chk("t6_cnt6", 32'(cnt), 6);
        tick();
        chk("t6_done", 32'(done), 1);
        chk("t6_q", 32'(q), 1);
        count = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cnt", 32'(cnt), 0);
        chk("t6_rst_q", 32'(q), 0);
        chk("t6_rst_valid", 32'(reg_valid), 0);
        chk("t6_rst_done", 32'(done), 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("t6_post_q", 32'(q), 0);
        chk("t6_post_cnt", 32'(cnt), 0);
        chk("t6_post_done", 32'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
